// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin share of one pipelined ALU among NREQ requesters, tag FIFO routes results back
// Optional macro ALU_ARB_PRIO0_EN gives requester 0 strict priority over the round-robin group.
module alu_arbiter #(
   parameter int NREQ = 4,
   parameter int WIDTH = 6,
   parameter int MAX_INFLIGHT = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NREQ-1:0]         req_valid_i,
   output logic [NREQ-1:0]         req_ready_o,
   input  logic [NREQ*2-1:0]       req_op_i,
   input  logic [NREQ*WIDTH-1:0]   req_a_i,
   input  logic [NREQ*WIDTH-1:0]   req_b_i,
   output logic                    alu_valid_o,
   output logic [1:0]              alu_op_o,
   output logic [WIDTH-1:0]        alu_sa_o,
   output logic [WIDTH-1:0]        alu_sb_o,
   input  logic                    alu_valid_i,
   input  logic [WIDTH-1:0]        alu_out_i,
   output logic [NREQ-1:0]         rsp_valid_o,
   output logic [WIDTH-1:0]        rsp_data_o,
   output logic                    busy_o,
   output logic                    err_o
);
   localparam int TAG_W = $clog2(NREQ);
   localparam int AW = MAX_INFLIGHT > 1 ? $clog2(MAX_INFLIGHT) : 1;
   localparam int CW = $clog2(MAX_INFLIGHT + 1);
   localparam logic [1:0] OP_NOP = 2'd0;
`ifdef ALU_ARB_PRIO0_EN
   localparam bit PRIO0 = 1'b1;
`else
   localparam bit PRIO0 = 1'b0;
`endif
   logic [TAG_W-1:0]   ptr, win;
   logic [2*NREQ-1:0]  rot;
   logic               hit, xfer, pop;
   logic [1:0]         sel_op;
   logic [WIDTH-1:0]   sel_a, sel_b;
   logic [TAG_W-1:0]   fifo [MAX_INFLIGHT];
   logic [AW-1:0]      wp, rp;
   logic [CW-1:0]      count;
   assign busy_o = count != '0;
   // Rotating the valids by ptr turns the wrap-around search into a plain lowest-bit search.
   always_comb begin
      rot = {req_valid_i, req_valid_i} >> ptr;
      win = '0;
      hit = 1'b0;
      sel_op = OP_NOP;
      sel_a = '0;
      sel_b = '0;
      for (int k = NREQ - 1; k >= 0; k--)
         if (rot[k]) begin
            win = TAG_W'((int'(ptr) + k) % NREQ);
            hit = 1'b1;
         end
      if (PRIO0 && req_valid_i[0]) win = '0;
      for (int i = 0; i < NREQ; i++)
         if (win == TAG_W'(i)) begin
            sel_op = req_op_i[2*i +: 2];
            sel_a = req_a_i[WIDTH*i +: WIDTH];
            sel_b = req_b_i[WIDTH*i +: WIDTH];
         end
      xfer = hit && count < CW'(MAX_INFLIGHT);
      req_ready_o = xfer ? NREQ'(1) << win : '0;
      pop = alu_valid_i && count != '0;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr <= '0;
         wp <= '0;
         rp <= '0;
         count <= '0;
         alu_valid_o <= 1'b0;
         alu_op_o <= OP_NOP;
         alu_sa_o <= '0;
         alu_sb_o <= '0;
         rsp_valid_o <= '0;
         rsp_data_o <= '0;
         err_o <= 1'b0;
      end else begin
         alu_valid_o <= xfer;
         alu_op_o <= xfer ? sel_op : OP_NOP;
         if (xfer) begin
            alu_sa_o <= sel_a;
            alu_sb_o <= sel_b;
            fifo[wp] <= win;
            wp <= wp + 1'b1;
         end
         if (xfer && !(PRIO0 && win == '0)) ptr <= win == TAG_W'(NREQ - 1) ? '0 : win + 1'b1;
         if (pop) begin
            rp <= rp + 1'b1;
            rsp_data_o <= alu_out_i;
         end
         rsp_valid_o <= pop ? NREQ'(1) << fifo[rp] : '0;
         count <= count + CW'(xfer) - CW'(pop);
         if (alu_valid_i && count == '0) err_o <= 1'b1;
      end
   end
endmodule
